// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Walks a raster of
// HTOTAL x VTOTAL pixels, where each line and each frame runs through the
// regions active, front porch, sync and back porch in that order.
// Generates syncs, blanking, line/frame strobes, a completed-frame counter
// and an optional colour-bar test pattern.
//
// Optional feature macro: VGA_PATTERN_EN
//   defined   -> patRgb carries 8 vertical colour bars during active video
//   undefined -> patRgb is tied to zero and no bar logic exists
//
// Ports:
//   vgaClk      in   1    pixel-domain clock
//   rstN        in   1    asynchronous active-low reset
//   pixEn       in   1    advance enable (one pixel per cycle while high)
//   hSync       out  1    horizontal sync, active level HPOL
//   vSync       out  1    vertical sync, active level VPOL
//   blankB      out  1    1 = active video, 0 = blanking
//   hCount      out  CW   current column, 0..HTOTAL-1
//   vCount      out  CW   current line, 0..VTOTAL-1
//   lineStart   out  1    one-cycle strobe on entry to hCount=0
//   frameStart  out  1    one-cycle strobe on entry to (0,0)
//   frameCount  out  FCW  completed-frame counter, wraps
//   patRgb      out  24   {R,G,B} test pattern
//
// pixEn contract: pixEn is a plain advance enable, not a handshake. A cycle
// with pixEn=1 moves the raster one pixel; a cycle with pixEn=0 freezes every
// output except the two strobes, which read 0 in any cycle that did not
// advance into a new line.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYNC   = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYNC   = 2,
    parameter int VBP     = 33,
    parameter bit HPOL    = 1'b0,
    parameter bit VPOL    = 1'b0,
    parameter int CW      = 10,
    parameter int FCW     = 8
) (
    input  logic           vgaClk,
    input  logic           rstN,
    input  logic           pixEn,
    output logic           hSync,
    output logic           vSync,
    output logic           blankB,
    output logic [CW-1:0]  hCount,
    output logic [CW-1:0]  vCount,
    output logic           lineStart,
    output logic           frameStart,
    output logic [FCW-1:0] frameCount,
    output logic [23:0]    patRgb
);

    localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;

    localparam logic [CW-1:0] H_LAST   = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(HACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(VACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(HACTIVE + HFP);
    localparam logic [CW-1:0] HS_END   = CW'(HACTIVE + HFP + HSYNC);
    localparam logic [CW-1:0] VS_START = CW'(VACTIVE + VFP);
    localparam logic [CW-1:0] VS_END   = CW'(VACTIVE + VFP + VSYNC);

    if ((HTOTAL - 1) >= (1 << CW) || (VTOTAL - 1) >= (1 << CW)) begin : gCwTooSmall
        $fatal(1, "vga_timing_gen: CW too small to hold HTOTAL-1 or VTOTAL-1");
    end

    logic          hWrap;
    logic          vLast;
    logic [CW-1:0] hNext;
    logic [CW-1:0] vNext;
    logic          hSyncNext;
    logic          vSyncNext;
    logic          activeNext;
    // Low until the first advance after reset, so that leaving the parked
    // position is not counted as a completed frame.
    logic          primed;

    // Decode is taken from the next counter values so that every registered
    // output describes the position presented in the same cycle.
    always_comb begin
        hWrap      = (hCount == H_LAST);
        vLast      = (vCount == V_LAST);
        hNext      = hWrap ? '0 : hCount + 1'b1;
        vNext      = vCount;
        if (hWrap) begin
            vNext = vLast ? '0 : vCount + 1'b1;
        end
        hSyncNext  = ((hNext >= HS_START) && (hNext < HS_END)) ? HPOL : ~HPOL;
        vSyncNext  = ((vNext >= VS_START) && (vNext < VS_END)) ? VPOL : ~VPOL;
        activeNext = (hNext < H_ACT) && (vNext < V_ACT);
    end

    always_ff @(posedge vgaClk or negedge rstN) begin
        if (!rstN) begin
            hCount     <= H_LAST;
            vCount     <= V_LAST;
            hSync      <= ~HPOL;
            vSync      <= ~VPOL;
            blankB     <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            frameCount <= '0;
            primed     <= 1'b0;
        end else if (pixEn) begin
            hCount     <= hNext;
            vCount     <= vNext;
            hSync      <= hSyncNext;
            vSync      <= vSyncNext;
            blankB     <= activeNext;
            lineStart  <= hWrap;
            frameStart <= hWrap && vLast;
            if (hWrap && vLast && primed) begin
                frameCount <= frameCount + 1'b1;
            end
            primed     <= 1'b1;
        end else begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end
    end

`ifdef VGA_PATTERN_EN
    // Bar width guarded against HACTIVE < 8 so the constant divide stays legal.
    localparam logic [CW-1:0] BAR_W = CW'((HACTIVE / 8 > 0) ? HACTIVE / 8 : 1);

    logic [CW-1:0] barQuot;
    logic [2:0]    barIdx;
    logic [23:0]   rgbNext;

    always_comb begin
        barQuot = hNext / BAR_W;
        barIdx  = (barQuot > CW'(7)) ? 3'd7 : barQuot[2:0];
        rgbNext = activeNext ? {{8{barIdx[2]}}, {8{barIdx[1]}}, {8{barIdx[0]}}} : 24'h0;
    end

    always_ff @(posedge vgaClk or negedge rstN) begin
        if (!rstN) begin
            patRgb <= 24'h0;
        end else if (pixEn) begin
            patRgb <= rgbNext;
        end
    end
`else
    assign patRgb = 24'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances: one with the default 640x480 geometry and one with a tiny
// 11x7 raster so that whole frames fit in a short run. The driver issues one
// cycle of stimulus per call and pushes the expected outputs for that cycle
// into a per-instance queue; a monitor per instance pops and compares one
// entry each cycle, just after the rising edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic        ls;
        logic        fs;
        logic [15:0] hc;
        logic [15:0] vc;
        logic [15:0] fc;
        logic [23:0] rgb;
    } obs_t;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstNDef  = 1'b0;
    logic pixEnDef = 1'b0;
    logic rstNSml  = 1'b0;
    logic pixEnSml = 1'b0;

    logic        hSyncD, vSyncD, blankBD, lineStartD, frameStartD;
    logic [9:0]  hCountD, vCountD;
    logic [7:0]  frameCountD;
    logic [23:0] patRgbD;

    logic        hSyncS, vSyncS, blankBS, lineStartS, frameStartS;
    logic [3:0]  hCountS, vCountS;
    logic [1:0]  frameCountS;
    logic [23:0] patRgbS;

    vga_timing_gen dutDef (
        .vgaClk(clk), .rstN(rstNDef), .pixEn(pixEnDef),
        .hSync(hSyncD), .vSync(vSyncD), .blankB(blankBD),
        .hCount(hCountD), .vCount(vCountD),
        .lineStart(lineStartD), .frameStart(frameStartD),
        .frameCount(frameCountD), .patRgb(patRgbD)
    );

    vga_timing_gen #(
        .HACTIVE(8), .HFP(1), .HSYNC(1), .HBP(1),
        .VACTIVE(4), .VFP(1), .VSYNC(1), .VBP(1),
        .HPOL(1'b1), .VPOL(1'b1), .CW(4), .FCW(2)
    ) dutSml (
        .vgaClk(clk), .rstN(rstNSml), .pixEn(pixEnSml),
        .hSync(hSyncS), .vSync(vSyncS), .blankB(blankBS),
        .hCount(hCountS), .vCount(vCountS),
        .lineStart(lineStartS), .frameStart(frameStartS),
        .frameCount(frameCountS), .patRgb(patRgbS)
    );

    // ---------------- hand-computed geometry (index 0 = default, 1 = small) ----------------
    int gHtot[2]  = '{800, 11};
    int gVtot[2]  = '{525, 7};
    int gHsLo[2]  = '{656, 9};
    int gHsHi[2]  = '{751, 9};
    int gVsLo[2]  = '{490, 5};
    int gVsHi[2]  = '{491, 5};
    int gHact[2]  = '{640, 8};
    int gVact[2]  = '{480, 4};
    int gBarW[2]  = '{80, 1};
    int gFcMod[2] = '{256, 4};
    bit gPol[2]   = '{1'b0, 1'b1};

    int mH[2], mV[2], mFc[2];
    bit mStarted[2];

    obs_t expQDef[$];
    obs_t expQSml[$];

    int nChecks = 0;
    int nFails  = 0;

    // ---------------- expected-value model ----------------
    function automatic obs_t expectedAt(int w, int h, int v, int fc, bit ls, bit fs);
        obs_t e;
        bit act;
`ifdef VGA_PATTERN_EN
        int b;
        logic [2:0] bb;
`endif
        act   = (h < gHact[w]) && (v < gVact[w]);
        e.hs  = (h >= gHsLo[w] && h <= gHsHi[w]) ? gPol[w] : ~gPol[w];
        e.vs  = (v >= gVsLo[w] && v <= gVsHi[w]) ? gPol[w] : ~gPol[w];
        e.bl  = act;
        e.ls  = ls;
        e.fs  = fs;
        e.hc  = 16'(h);
        e.vc  = 16'(v);
        e.fc  = 16'(fc);
        e.rgb = 24'h0;
`ifdef VGA_PATTERN_EN
        if (act) begin
            b  = h / gBarW[w];
            if (b > 7) b = 7;
            bb = 3'(b);
            e.rgb = {{8{bb[2]}}, {8{bb[1]}}, {8{bb[0]}}};
        end
`endif
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input int w, input bit r, input bit en);
        bit ls, fs;
        obs_t e;
        @(negedge clk);
        if (w == 0) begin
            rstNDef = r; pixEnDef = en;
        end else begin
            rstNSml = r; pixEnSml = en;
        end
        ls = 1'b0;
        fs = 1'b0;
        if (!r) begin
            mH[w] = gHtot[w] - 1;
            mV[w] = gVtot[w] - 1;
            mFc[w] = 0;
            mStarted[w] = 1'b0;
        end else if (en) begin
            if (mH[w] == gHtot[w] - 1) begin
                ls = 1'b1;
                mH[w] = 0;
                if (mV[w] == gVtot[w] - 1) begin
                    fs = 1'b1;
                    mV[w] = 0;
                    if (mStarted[w]) mFc[w] = (mFc[w] + 1) % gFcMod[w];
                end else begin
                    mV[w] = mV[w] + 1;
                end
            end else begin
                mH[w] = mH[w] + 1;
            end
            mStarted[w] = 1'b1;
        end
        e = expectedAt(w, mH[w], mV[w], mFc[w], ls, fs);
        if (w == 0) expQDef.push_back(e);
        else        expQSml.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    bit statsDef = 1'b0;
    int lsCntDef = 0, hsLowDef = 0, blankLowDef = 0;

    bit statsSml = 1'b0;
    int cyc = 0;
    int fsStamp[$];
    int fsFc[$];

    always begin : monDef
        obs_t e, a;
        @(posedge clk);
        #1;
        if (expQDef.size() > 0) begin
            e = expQDef.pop_front();
            a = '{hSyncD, vSyncD, blankBD, lineStartD, frameStartD,
                  16'(hCountD), 16'(vCountD), 16'(frameCountD), patRgbD};
            nChecks++;
            if (a !== e) begin
                nFails++;
                $display("FAIL def_scoreboard t=%0t act(h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d rgb=%h) exp(h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d rgb=%h)",
                         $time, a.hc, a.vc, a.hs, a.vs, a.bl, a.ls, a.fs, a.fc, a.rgb,
                         e.hc, e.vc, e.hs, e.vs, e.bl, e.ls, e.fs, e.fc, e.rgb);
            end
            if (statsDef) begin
                if (a.ls)  lsCntDef++;
                if (!a.hs) hsLowDef++;
                if (!a.bl) blankLowDef++;
            end
        end
    end

    always begin : monSml
        obs_t e, a;
        @(posedge clk);
        #1;
        cyc++;
        if (expQSml.size() > 0) begin
            e = expQSml.pop_front();
            a = '{hSyncS, vSyncS, blankBS, lineStartS, frameStartS,
                  16'(hCountS), 16'(vCountS), 16'(frameCountS), patRgbS};
            nChecks++;
            if (a !== e) begin
                nFails++;
                $display("FAIL sml_scoreboard t=%0t act(h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d rgb=%h) exp(h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d rgb=%h)",
                         $time, a.hc, a.vc, a.hs, a.vs, a.bl, a.ls, a.fs, a.fc, a.rgb,
                         e.hc, e.vc, e.hs, e.vs, e.bl, e.ls, e.fs, e.fc, e.rgb);
            end
            if (statsSml && a.fs) begin
                fsStamp.push_back(cyc);
                fsFc.push_back(int'(a.fc));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    int fcSeq[5] = '{0, 1, 2, 3, 0};

    initial begin
        // Default geometry: reset values, then release straight into (0,0).
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b0);
        settle();
        lsCntDef = 0; hsLowDef = 0; blankLowDef = 0; statsDef = 1'b1;
        for (int i = 0; i < 1600; i++) drive(0, 1'b1, 1'b1);
        settle();
        statsDef = 1'b0;
        checkVal("def_lineStart_count_2lines", lsCntDef, 2);
        checkVal("def_hSync_low_cycles_2lines", hsLowDef, 192);
        checkVal("def_blank_cycles_2lines", blankLowDef, 320);

        // Default geometry at 50% pixEn duty: one more line over 1600 cycles.
        lsCntDef = 0; hsLowDef = 0; blankLowDef = 0; statsDef = 1'b1;
        for (int i = 0; i < 1600; i++) drive(0, 1'b1, (i % 2) == 0);
        settle();
        statsDef = 1'b0;
        checkVal("def_half_lineStart_count", lsCntDef, 1);
        checkVal("def_half_hSync_low_cycles", hsLowDef, 192);
        checkVal("def_half_blank_cycles", blankLowDef, 320);

        // Small geometry: five frames at full rate.
        for (int i = 0; i < 2; i++) drive(1, 1'b0, 1'b0);
        settle();
        fsStamp.delete(); fsFc.delete(); statsSml = 1'b1;
        for (int i = 0; i < 385; i++) drive(1, 1'b1, 1'b1);
        settle();
        checkVal("sml_frameStart_count", fsStamp.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < fsFc.size()) checkVal("sml_frameCount_seq", fsFc[i], fcSeq[i]);
        end
        for (int i = 1; i < fsStamp.size(); i++) begin
            checkVal("sml_frame_period", fsStamp[i] - fsStamp[i-1], 77);
        end

        // Small geometry: two frames at 50% pixEn duty.
        fsStamp.delete(); fsFc.delete();
        for (int i = 0; i < 308; i++) drive(1, 1'b1, (i % 2) == 0);
        settle();
        checkVal("sml_half_frameStart_count", fsStamp.size(), 2);
        if (fsStamp.size() == 2) checkVal("sml_half_frame_period", fsStamp[1] - fsStamp[0], 154);

        // Move to (5,2), then assert reset asynchronously mid-frame.
        for (int i = 0; i < 28; i++) drive(1, 1'b1, 1'b1);
        settle();
        checkVal("sml_pre_reset_h", int'(hCountS), 5);
        checkVal("sml_pre_reset_v", int'(vCountS), 2);
        fsStamp.delete(); fsFc.delete();
        drive(1, 1'b0, 1'b0);
        #1;
        checkVal("sml_async_park_h", int'(hCountS), 10);
        checkVal("sml_async_park_v", int'(vCountS), 6);
        checkVal("sml_async_hSync_idle", int'(hSyncS), 0);
        checkVal("sml_async_vSync_idle", int'(vSyncS), 0);
        checkVal("sml_async_blankB", int'(blankBS), 0);
        checkVal("sml_async_frameCount", int'(frameCountS), 0);
        drive(1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) drive(1, 1'b1, 1'b1);
        settle();
        checkVal("sml_post_reset_frameStarts", fsStamp.size(), 1);
        if (fsFc.size() > 0) checkVal("sml_post_reset_frameCount", fsFc[0], 0);
        statsSml = 1'b0;

        settle();
        checkVal("def_queue_drain", expQDef.size(), 0);
        checkVal("sml_queue_drain", expQSml.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
